// File: rtl/data_selector_nto1_reg_pkg.sv
// rtl/data_selector_nto1_reg_pkg.sv - shared constants for the registered N-to-1 selector
package data_selector_nto1_reg_pkg;

  localparam int MODE_EXT = 0;
  localparam int MODE_RR  = 1;

  // Next round-robin start position after channel idx of n was taken.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/data_selector_nto1_reg_rr_arbiter_n.sv
// rtl/data_selector_nto1_reg_rr_arbiter_n.sv - combinational round-robin grant search from ptr
module rr_arbiter_n #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W:0] pos;

  // Walk from the far end back to ptr so the nearest requester is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    pos         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (SEL_W + 1)'(i);
      if (pos >= (SEL_W + 1)'(N)) begin
        pos = pos - (SEL_W + 1)'(N);
      end
      if (req[pos[SEL_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = pos[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/data_selector_nto1_reg.sv
// rtl/data_selector_nto1_reg.sv - registered N-to-1 selector with valid/ready per channel
module data_selector_nto1_reg
  import data_selector_nto1_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N),
  parameter int MODE  = MODE_EXT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   Control,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             slot_free;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] grant_data;
  logic             accept;

  assign slot_free = !out_valid || out_ready;
  assign accept    = slot_free && grant_valid;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter_n #(
        .N     (N),
        .SEL_W (SEL_W)
      ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
      );
    end else begin : g_ext
      // Compare rather than index so an out-of-range Control simply matches nothing.
      always_comb begin
        grant_valid = 1'b0;
        grant_idx   = Control;
        for (int k = 0; k < N; k++) begin
          if (Control == SEL_W'(k)) begin
            grant_valid = in_valid[k];
          end
        end
      end
    end
  endgenerate

  // Ready follows the candidate index only, never that channel's own valid.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (RST && slot_free && grant_idx == SEL_W'(k)) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_idx;
        if (MODE == MODE_RR) begin
          ptr <= SEL_W'(wrap_inc(int'(grant_idx), N));
        end
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_selector_nto1_reg.sv
// tb/tb_data_selector_nto1_reg.sv - randomized and directed checks against a reference model
module tb_data_selector_nto1_reg;

  logic clk;
  logic RST;

  logic [127:0] a_data;  logic [3:0] a_valid, a_irdy;  logic [1:0] a_ctrl;
  logic [31:0]  a_odata; logic [1:0] a_osel;  logic a_ovalid, a_ordy;
  logic [127:0] b_data;  logic [3:0] b_valid, b_irdy;  logic [1:0] b_ctrl;
  logic [31:0]  b_odata; logic [1:0] b_osel;  logic b_ovalid, b_ordy;
  logic [159:0] c_data;  logic [4:0] c_valid, c_irdy;  logic [2:0] c_ctrl;
  logic [31:0]  c_odata; logic [2:0] c_osel;  logic c_ovalid, c_ordy;

  int checks = 0;
  int errors = 0;

  logic        m_valid [3];
  logic [31:0] m_data  [3];
  int          m_sel   [3];
  int          m_ptr   [3];

  data_selector_nto1_reg #(.WIDTH(32), .N(4), .MODE(0)) u_a (
    .CLK(clk), .RST(RST), .in_data(a_data), .in_valid(a_valid), .in_ready(a_irdy),
    .Control(a_ctrl), .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovalid), .out_ready(a_ordy));
  data_selector_nto1_reg #(.WIDTH(32), .N(4), .MODE(1)) u_b (
    .CLK(clk), .RST(RST), .in_data(b_data), .in_valid(b_valid), .in_ready(b_irdy),
    .Control(b_ctrl), .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovalid), .out_ready(b_ordy));
  data_selector_nto1_reg #(.WIDTH(32), .N(5), .MODE(0)) u_c (
    .CLK(clk), .RST(RST), .in_data(c_data), .in_valid(c_valid), .in_ready(c_irdy),
    .Control(c_ctrl), .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovalid), .out_ready(c_ordy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 1'b0; m_data[d] = '0; m_sel[d] = 0; m_ptr[d] = 0;
    end
  endtask

  // Which channel the rules say should be taken this cycle, if any.
  task automatic predict(input int d, input int n, input int mode, input logic [15:0] v,
                         input int ctrl, output bit found, output int g);
    found = 0; g = 0;
    if (mode == 0) begin
      if (ctrl < n && v[ctrl]) begin found = 1; g = ctrl; end
    end else begin
      for (int i = 0; i < n && !found; i++) begin
        if (v[(m_ptr[d] + i) % n]) begin found = 1; g = (m_ptr[d] + i) % n; end
      end
    end
  endtask

  task automatic pre_check(input int d, input int n, input int mode, input logic [15:0] v,
                           input int ctrl, input logic ordy, input logic [15:0] irdy, input string tag);
    bit found; int g;
    predict(d, n, mode, v, ctrl, found, g);
    if (m_valid[d] && !ordy) chk({tag, "_stall_ready"}, 64'(irdy), 64'd0);
    else if (found)          chk({tag, "_grant_ready"}, 64'(irdy[g]), 64'd1);
    chk({tag, "_ready_onehot0"}, 64'($onehot0(irdy)), 64'd1);
  endtask

  task automatic model_step(input int d, input int n, input int mode, input logic [15:0] v,
                            input logic [159:0] data, input int ctrl, input logic ordy);
    bit found; int g;
    if (!m_valid[d] || ordy) begin
      predict(d, n, mode, v, ctrl, found, g);
      if (found) begin
        m_valid[d] = 1'b1;
        m_data[d]  = data[g*32 +: 32];
        m_sel[d]   = g;
        if (mode == 1) m_ptr[d] = (g + 1) % n;
      end else begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  task automatic post_check(input int d, input logic ov, input logic [31:0] od,
                            input logic [2:0] os, input string tag);
    chk({tag, "_out_valid"}, 64'(ov), 64'(m_valid[d]));
    chk({tag, "_out_data"},  64'(od), 64'(m_data[d]));
    chk({tag, "_out_sel"},   64'(os), 64'(m_sel[d]));
  endtask

  // Inputs are stable from here to the edge; outputs are sampled 1 time unit after it.
  task automatic cycle();
    #1;
    if (!RST) begin
      chk("a_reset_ready", 64'(a_irdy), 64'd0);
      chk("b_reset_ready", 64'(b_irdy), 64'd0);
      chk("c_reset_ready", 64'(c_irdy), 64'd0);
    end else begin
      pre_check(0, 4, 0, 16'(a_valid), int'(a_ctrl), a_ordy, 16'(a_irdy), "a");
      pre_check(1, 4, 1, 16'(b_valid), int'(b_ctrl), b_ordy, 16'(b_irdy), "b");
      pre_check(2, 5, 0, 16'(c_valid), int'(c_ctrl), c_ordy, 16'(c_irdy), "c");
    end
    @(posedge clk);
    if (!RST) model_reset();
    else begin
      model_step(0, 4, 0, 16'(a_valid), 160'(a_data), int'(a_ctrl), a_ordy);
      model_step(1, 4, 1, 16'(b_valid), 160'(b_data), int'(b_ctrl), b_ordy);
      model_step(2, 5, 0, 16'(c_valid), c_data, int'(c_ctrl), c_ordy);
    end
    #1;
    post_check(0, a_ovalid, a_odata, 3'(a_osel), "a");
    post_check(1, b_ovalid, b_odata, 3'(b_osel), "b");
    post_check(2, c_ovalid, c_odata, c_osel, "c");
  endtask

  initial begin
    int seq4 [5];
    int seq13 [4];
    seq4  = '{0, 1, 2, 3, 0};
    seq13 = '{1, 3, 1, 3};
    model_reset();
    RST = 1'b0;
    a_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    a_valid = 4'hF; a_ctrl = 2'd0; a_ordy = 1'b1;
    b_data = a_data; b_valid = 4'hF; b_ctrl = 2'd0; b_ordy = 1'b1;
    c_data = '0; c_valid = 5'h1F; c_ctrl = 3'd0; c_ordy = 1'b1;

    // Reset held with every channel valid
    cycle(); cycle();
    chk("reset_out_valid", 64'(a_ovalid), 64'd0);
    chk("reset_out_data", 64'(a_odata), 64'd0);
    RST = 1'b1;
    b_valid = 4'h0; c_valid = 5'h0;
    cycle();
    chk("first_accept_valid", 64'(a_ovalid), 64'd1);
    chk("first_accept_data", 64'(a_odata), 64'h1111_1111);

    // External select of channel 2, then channel 2 idle
    a_ctrl = 2'd2; a_data[64 +: 32] = 32'hDEAD_BEEF;
    cycle();
    chk("ext_ch2_data", 64'(a_odata), 64'hDEAD_BEEF);
    chk("ext_ch2_sel", 64'(a_osel), 64'd2);
    a_valid[2] = 1'b0;
    cycle();
    chk("ext_ch2_idle_valid", 64'(a_ovalid), 64'd0);

    // Stall for three cycles while select and data wander
    a_valid = 4'hF; a_ctrl = 2'd1; a_data[32 +: 32] = 32'h11;
    cycle();
    a_ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_ctrl = 2'($urandom_range(0, 3));
      a_data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      chk("stall_hold_data", 64'(a_odata), 64'h11);
      chk("stall_hold_valid", 64'(a_ovalid), 64'd1);
    end
    a_ordy = 1'b1; a_ctrl = 2'd0; a_data[31:0] = 32'h22;
    cycle();
    chk("stall_release_data", 64'(a_odata), 64'h22);
    chk("stall_release_valid", 64'(a_ovalid), 64'd1);

    // Round-robin over all four channels, then only 1 and 3
    b_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_all_sel", 64'(b_osel), 64'(seq4[i]));
    end
    b_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_odd_sel", 64'(b_osel), 64'(seq13[i]));
    end

    // Out-of-range select on the five-channel instance
    c_valid = 5'h1F; c_data = {5{$urandom}};
    c_ctrl = 3'd5; cycle();
    chk("oor5_valid", 64'(c_ovalid), 64'd0);
    chk("oor5_data", 64'(c_odata), 64'd0);
    c_ctrl = 3'd7; cycle();
    chk("oor7_valid", 64'(c_ovalid), 64'd0);
    c_ctrl = 3'd4; cycle();
    chk("c_ch4_sel", 64'(c_osel), 64'd4);

    // Asynchronous reset between edges while both instances are stalled
    b_valid = 4'hF; a_ctrl = 2'd3;
    cycle();
    a_ordy = 1'b0; b_ordy = 1'b0;
    cycle();
    #3;
    RST = 1'b0;
    #1;
    chk("async_a_valid", 64'(a_ovalid), 64'd0);
    chk("async_b_valid", 64'(b_ovalid), 64'd0);
    chk("async_b_sel", 64'(b_osel), 64'd0);
    model_reset();
    cycle();
    RST = 1'b1; a_ordy = 1'b1; b_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rr_restart_sel", 64'(b_osel), 64'(seq4[i]));
    end

    // Random traffic on all three instances
    for (int i = 0; i < 400; i++) begin
      a_valid = 4'($urandom); b_valid = 4'($urandom); c_valid = 5'($urandom);
      a_data = {$urandom, $urandom, $urandom, $urandom};
      b_data = {$urandom, $urandom, $urandom, $urandom};
      c_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      a_ctrl = 2'($urandom_range(0, 3)); b_ctrl = 2'($urandom);
      c_ctrl = 3'($urandom_range(0, 7));
      a_ordy = ($urandom_range(0, 3) != 0);
      b_ordy = ($urandom_range(0, 3) != 0);
      c_ordy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
